hash_result_serializer: RTL and testbench

Consumer at the output end of the hash engine. Accepts one wide hash-result beat per handshake (ISSUE_WIDTH lanes, each with an optional history candidate) and emits the surviving candidates one per cycle in ascending lane order, tagged with absolute head address. The scalar stream feeds the downstream match-extension PE. Beat boundaries and block delimiters are preserved in-band.

---
 rtl/hash_result_serializer_if.sv | 53 +++++
 rtl/hash_result_serializer.sv | 149 ++++++++++++++
 tb/tb_hash_result_serializer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hash_result_serializer_if.sv
// Beat bus (hash engine -> serializer) and scalar token bus (serializer -> match-extension PE).
// Master drives payload and valid; slave drives ready.
interface hash_result_beat_if #(
  parameter int ISSUE_WIDTH          = 32,
  parameter int ADDR_WIDTH           = 32,
  parameter int META_MATCH_LEN_WIDTH = 5
);
  logic                                        input_valid;
  logic                                        input_ready;
  logic [ADDR_WIDTH-1:0]                       input_head_addr;
  logic [ISSUE_WIDTH-1:0]                      input_history_valid;
  logic [ISSUE_WIDTH*ADDR_WIDTH-1:0]           input_history_addr;
  logic [ISSUE_WIDTH*META_MATCH_LEN_WIDTH-1:0] input_meta_match_len;
  logic [ISSUE_WIDTH-1:0]                      input_meta_match_can_ext;
  logic                                        input_delim;

  modport master (
    output input_valid, input_head_addr, input_history_valid, input_history_addr,
           input_meta_match_len, input_meta_match_can_ext, input_delim,
    input  input_ready
  );
  modport slave (
    input  input_valid, input_head_addr, input_history_valid, input_history_addr,
           input_meta_match_len, input_meta_match_can_ext, input_delim,
    output input_ready
  );
endinterface

interface hash_result_token_if #(
  parameter int ADDR_WIDTH           = 32,
  parameter int META_MATCH_LEN_WIDTH = 5
);
  logic                            output_valid;
  logic                            output_ready;
  logic                            output_cand;
  logic [ADDR_WIDTH-1:0]           output_addr;
  logic [ADDR_WIDTH-1:0]           output_history_addr;
  logic [META_MATCH_LEN_WIDTH-1:0] output_meta_match_len;
  logic                            output_meta_match_can_ext;
  logic                            output_last;
  logic                            output_delim;

  modport master (
    output output_valid, output_cand, output_addr, output_history_addr,
           output_meta_match_len, output_meta_match_can_ext, output_last, output_delim,
    input  output_ready
  );
  modport slave (
    input  output_valid, output_cand, output_addr, output_history_addr,
           output_meta_match_len, output_meta_match_can_ext, output_last, output_delim,
    output output_ready
  );
endinterface

// File: rtl/hash_result_serializer.sv
// Serializes surviving hash candidates of one wide beat into one token per cycle, lowest lane first.
// First token one cycle after acceptance; a new beat is taken on the last-token handshake, tokens hold under backpressure.
module hash_result_serializer #(
  parameter int ISSUE_WIDTH          = 32,
  parameter int ISSUE_WIDTH_LOG2     = 5,
  parameter int ADDR_WIDTH           = 32,
  parameter int META_MATCH_LEN_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [META_MATCH_LEN_WIDTH-1:0] cfg_min_match_len,
  hash_result_beat_if.slave               beat,
  hash_result_token_if.master             tok
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]           hist_addr;
    logic [META_MATCH_LEN_WIDTH-1:0] len;
    logic                            can_ext;
  } lane_t;

  typedef enum logic [1:0] {
    EMPTY      = 2'd0,
    DRAIN      = 2'd1,
    DELIM_ONLY = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [ISSUE_WIDTH-1:0]      pending_q, pending_d;
  logic                        delim_q;
  logic [ADDR_WIDTH-1:0]       head_q;
  lane_t                       lane_q  [ISSUE_WIDTH];
  lane_t                       lane_in [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0]      survive;
  logic [ISSUE_WIDTH_LOG2-1:0] sel_idx;
  logic [ISSUE_WIDTH-1:0]      sel_onehot;
  logic                        sel_is_last;
  logic                        out_fire;
  logic                        accept;

  // Unpack the flat lane buses and apply the survivor filter
  always_comb begin
    survive = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      lane_in[i].hist_addr = beat.input_history_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      lane_in[i].len       = beat.input_meta_match_len[i*META_MATCH_LEN_WIDTH +: META_MATCH_LEN_WIDTH];
      lane_in[i].can_ext   = beat.input_meta_match_can_ext[i];
      survive[i]           = beat.input_history_valid[i] &
                             (lane_in[i].can_ext | (lane_in[i].len >= cfg_min_match_len));
    end
  end

  // Lowest pending lane wins; descending scan leaves the smallest index last
  always_comb begin
    sel_idx = '0;
    for (int i = ISSUE_WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx = ISSUE_WIDTH_LOG2'(i);
      end
    end
  end

  assign sel_onehot  = pending_q & (~pending_q + ISSUE_WIDTH'(1));
  assign sel_is_last = ~|(pending_q & (pending_q - ISSUE_WIDTH'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d                       = state_q;
    pending_d                     = pending_q;
    tok.output_valid              = 1'b0;
    tok.output_cand               = 1'b0;
    tok.output_addr               = '0;
    tok.output_history_addr       = '0;
    tok.output_meta_match_len     = '0;
    tok.output_meta_match_can_ext = 1'b0;
    tok.output_last               = 1'b0;
    tok.output_delim              = 1'b0;

    case (state_q)
      DRAIN: begin
        tok.output_valid              = 1'b1;
        tok.output_cand               = 1'b1;
        tok.output_addr               = head_q + ADDR_WIDTH'(sel_idx);
        tok.output_history_addr       = lane_q[sel_idx].hist_addr;
        tok.output_meta_match_len     = lane_q[sel_idx].len;
        tok.output_meta_match_can_ext = lane_q[sel_idx].can_ext;
        tok.output_last               = sel_is_last;
        tok.output_delim              = sel_is_last & delim_q;
      end
      DELIM_ONLY: begin
        tok.output_valid = 1'b1;
        tok.output_last  = 1'b1;
        tok.output_delim = delim_q;
      end
      default: ;
    endcase

    out_fire         = tok.output_valid & tok.output_ready;
    beat.input_ready = (state_q == EMPTY) | (out_fire & tok.output_last);
    accept           = beat.input_valid & beat.input_ready;

    if (out_fire) begin
      pending_d = pending_q & ~sel_onehot;
      if (tok.output_last) begin
        state_d = EMPTY;
      end
    end

    // A beat taken on the final handshake replaces the draining one without a bubble
    if (accept) begin
      pending_d = survive;
      if (|survive) begin
        state_d = DRAIN;
      end else if (beat.input_delim) begin
        state_d = DELIM_ONLY;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      delim_q   <= 1'b0;
      head_q    <= '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      if (accept) begin
        delim_q <= beat.input_delim;
        head_q  <= beat.input_head_addr;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
          lane_q[i] <= lane_in[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_hash_result_serializer.sv
// Directed bench: stimulus pushes hand-computed tokens into a scoreboard, a negedge monitor pops and compares.
module tb_hash_result_serializer;
  localparam int IW  = 32;
  localparam int IWL = 5;
  localparam int AW  = 32;
  localparam int ML  = 5;

  typedef struct packed {
    logic          cand;
    logic [AW-1:0] addr;
    logic [AW-1:0] hist;
    logic [ML-1:0] len;
    logic          ext;
    logic          last;
    logic          delim;
  } tok_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [ML-1:0] cfg;

  hash_result_beat_if  #(.ISSUE_WIDTH(IW), .ADDR_WIDTH(AW), .META_MATCH_LEN_WIDTH(ML)) beat ();
  hash_result_token_if #(.ADDR_WIDTH(AW), .META_MATCH_LEN_WIDTH(ML)) tok ();

  hash_result_serializer #(
    .ISSUE_WIDTH(IW), .ISSUE_WIDTH_LOG2(IWL), .ADDR_WIDTH(AW), .META_MATCH_LEN_WIDTH(ML)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_min_match_len (cfg),
    .beat              (beat),
    .tok               (tok)
  );

  always #5 clk = ~clk;

  tok_t sb[$];
  int   hs_cyc[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ready_mode = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic tok_t cur_tok();
    return '{tok.output_cand, tok.output_addr, tok.output_history_addr,
             tok.output_meta_match_len, tok.output_meta_match_can_ext,
             tok.output_last, tok.output_delim};
  endfunction

  // Monitor: compares each handshake against the scoreboard and checks hold while stalled
  initial begin
    tok_t snap;
    tok_t e;
    tok_t c;
    bit   snap_vld = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        snap_vld = 0;
      end else begin
        c = cur_tok();
        if (snap_vld) begin
          check("stall_valid_held", tok.output_valid, 1);
          check("stall_fields_held", c[63:0], snap[63:0]);
          check("stall_fields_held_hi", 64'(c[72:64]), 64'(snap[72:64]));
        end
        if (tok.output_valid && tok.output_ready) begin
          hs_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_token: got addr 0x%0h cand %0d, expected no token", c.addr, c.cand);
          end else begin
            e = sb.pop_front();
            check("tok_cand",  c.cand,  e.cand);
            check("tok_addr",  c.addr,  e.addr);
            check("tok_hist",  c.hist,  e.hist);
            check("tok_len",   c.len,   e.len);
            check("tok_ext",   c.ext,   e.ext);
            check("tok_last",  c.last,  e.last);
            check("tok_delim", c.delim, e.delim);
          end
        end
        snap_vld = tok.output_valid && !tok.output_ready;
        snap     = c;
      end
    end
  end

  initial begin
    tok.output_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tok.output_ready = 1'b1;
        1:       tok.output_ready = ~tok.output_ready;
        default: tok.output_ready = 1'b0;
      endcase
    end
  end

  task automatic clr_beat();
    beat.input_head_addr          = '0;
    beat.input_history_valid      = '0;
    beat.input_history_addr       = '0;
    beat.input_meta_match_len     = '0;
    beat.input_meta_match_can_ext = '0;
    beat.input_delim              = 1'b0;
  endtask

  // Lane i history address is 0xA000_0000 + 16*i throughout
  task automatic set_lane(int i, logic [ML-1:0] len, logic ext);
    beat.input_history_valid[i]                   = 1'b1;
    beat.input_history_addr[i*AW +: AW]           = 32'hA000_0000 + 32'(i * 16);
    beat.input_meta_match_len[i*ML +: ML]         = len;
    beat.input_meta_match_can_ext[i]              = ext;
  endtask

  task automatic push_tok(logic cand, logic [AW-1:0] addr, logic [AW-1:0] hist,
                          logic [ML-1:0] len, logic ext, logic last, logic delim);
    sb.push_back('{cand, addr, hist, len, ext, last, delim});
  endtask

  task automatic send_beat();
    bit ok = 0;
    beat.input_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = beat.input_ready;
      @(posedge clk);
      #1;
    end
    beat.input_valid = 1'b0;
    acc_cyc = cyc;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got input_ready 0 for 50 cycles, expected 1");
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    int acc_a;
    int acc_b;
    beat.input_valid = 1'b0;
    clr_beat();
    cfg = 5'd4;

    // Reset values, asynchronously with no clock edge needed
    #1 rst = 1'b1;
    #2;
    check("rst_valid", tok.output_valid, 0);
    check("rst_input_ready", beat.input_ready, 1);
    check("rst_cand", tok.output_cand, 0);
    check("rst_addr", tok.output_addr, 0);
    check("rst_hist", tok.output_history_addr, 0);
    check("rst_len", tok.output_meta_match_len, 0);
    check("rst_ext", tok.output_meta_match_can_ext, 0);
    check("rst_last", tok.output_last, 0);
    check("rst_delim", tok.output_delim, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Lanes 0, 2, 31: three tokens on consecutive cycles starting right after acceptance
    hs_cyc.delete();
    clr_beat();
    beat.input_head_addr = 32'h0000_1000;
    set_lane(0, 8, 0);
    set_lane(2, 8, 0);
    set_lane(31, 8, 0);
    push_tok(1, 32'h0000_1000, 32'hA000_0000, 8, 0, 0, 0);
    push_tok(1, 32'h0000_1002, 32'hA000_0020, 8, 0, 0, 0);
    push_tok(1, 32'h0000_101F, 32'hA000_01F0, 8, 0, 1, 0);
    send_beat();
    wait_drain();
    check("t1_count", hs_cyc.size(), 3);
    check("t1_first_latency", hs_cyc[0], acc_cyc);
    check("t1_second_cycle", hs_cyc[1], acc_cyc + 1);
    check("t1_third_cycle", hs_cyc[2], acc_cyc + 2);

    // Delimiter-only beat, then an empty non-delimited beat that yields nothing
    hs_cyc.delete();
    clr_beat();
    beat.input_head_addr = 32'h0000_7777;
    beat.input_delim     = 1'b1;
    push_tok(0, 0, 0, 0, 0, 1, 1);
    send_beat();
    wait_drain();
    check("t2_delim_count", hs_cyc.size(), 1);
    clr_beat();
    beat.input_head_addr = 32'h0000_8888;
    send_beat();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t2_empty_ready", beat.input_ready, 1);
      check("t2_empty_no_valid", tok.output_valid, 0);
    end
    @(posedge clk);
    #1;

    // Filter: lane 1 kept by can_ext, lane 2 dropped by length
    clr_beat();
    cfg = 5'd8;
    beat.input_head_addr = 32'h0000_3000;
    set_lane(1, 2, 1);
    set_lane(2, 7, 0);
    push_tok(1, 32'h0000_3001, 32'hA000_0010, 2, 1, 1, 0);
    send_beat();
    wait_drain();

    // Two back-to-back beats: second accepted on the first beat's last handshake
    hs_cyc.delete();
    cfg = 5'd4;
    push_tok(1, 32'h0000_4004, 32'hA000_0040, 8, 0, 0, 0);
    push_tok(1, 32'h0000_4005, 32'hA000_0050, 8, 0, 1, 0);
    push_tok(1, 32'h0000_5000, 32'hA000_0000, 8, 0, 0, 0);
    push_tok(1, 32'h0000_5001, 32'hA000_0010, 8, 0, 1, 0);
    clr_beat();
    beat.input_head_addr = 32'h0000_4000;
    set_lane(4, 8, 0);
    set_lane(5, 8, 0);
    send_beat();
    acc_a = acc_cyc;
    clr_beat();
    beat.input_head_addr = 32'h0000_5000;
    set_lane(0, 8, 0);
    set_lane(1, 8, 0);
    send_beat();
    acc_b = acc_cyc;
    wait_drain();
    check("t4_count", hs_cyc.size(), 4);
    for (int i = 0; i < 4; i++) check("t4_consecutive", hs_cyc[i], acc_a + i);
    check("t4_b_accept_on_last", acc_b, hs_cyc[1] + 1);

    // Toggling output_ready: tokens held while stalled, one handshake every other cycle
    hs_cyc.delete();
    ready_mode = 1;
    clr_beat();
    beat.input_head_addr = 32'h0000_2000;
    beat.input_delim     = 1'b1;
    set_lane(0, 8, 0);
    set_lane(3, 8, 0);
    set_lane(7, 8, 0);
    set_lane(9, 8, 0);
    push_tok(1, 32'h0000_2000, 32'hA000_0000, 8, 0, 0, 0);
    push_tok(1, 32'h0000_2003, 32'hA000_0030, 8, 0, 0, 0);
    push_tok(1, 32'h0000_2007, 32'hA000_0070, 8, 0, 0, 0);
    push_tok(1, 32'h0000_2009, 32'hA000_0090, 8, 0, 1, 1);
    send_beat();
    wait_drain();
    ready_mode = 0;
    check("t5_count", hs_cyc.size(), 4);
    for (int i = 1; i < 4; i++) check("t5_spacing", hs_cyc[i], hs_cyc[0] + 2 * i);
    @(posedge clk);
    #1;

    // Address wrap at the top of the address space
    clr_beat();
    beat.input_head_addr = 32'hFFFF_FFF0;
    set_lane(31, 8, 0);
    push_tok(1, 32'h0000_000F, 32'hA000_01F0, 8, 0, 1, 0);
    send_beat();
    wait_drain();

    // Reset mid-drain drops pending tokens immediately
    ready_mode = 2;
    @(posedge clk);
    #2;
    clr_beat();
    beat.input_head_addr = 32'h0000_6000;
    for (int i = 0; i < 4; i++) set_lane(i, 8, 0);
    send_beat();
    @(posedge clk);
    #3;
    check("t6_valid_before_rst", tok.output_valid, 1);
    rst = 1'b1;
    #1;
    sb.delete();
    check("t6_rst_valid", tok.output_valid, 0);
    check("t6_rst_input_ready", beat.input_ready, 1);
    check("t6_rst_last", tok.output_last, 0);
    check("t6_rst_addr", tok.output_addr, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    ready_mode = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t6_no_stale_token", tok.output_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, expected summary");
    $fatal(1);
  end

endmodule
